// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared types and constants for the shift sequencer
package shift_sequencer_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_STAGES = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_SLL = 1'b0,
        OP_SRA = 1'b1
    } op_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result signal bundle for the shift sequencer
interface shift_sequencer_if;
    import shift_sequencer_pkg::*;

    logic              ctrl_shift;
    logic              ctrl_op;
    logic [DATA_W-1:0] data_operandA;
    logic [4:0]        ctrl_shiftamt;
    logic [DATA_W-1:0] data_result;
    logic              data_resultRDY;
    logic              busy;

    modport master (
        output ctrl_shift, ctrl_op, data_operandA, ctrl_shiftamt,
        input  data_result, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_shift, ctrl_op, data_operandA, ctrl_shiftamt,
        output data_result, data_resultRDY, busy
    );

endinterface

// File: rtl/shift_sequencer_shift_stage.sv
// rtl/shift_sequencer_shift_stage.sv - one fixed-distance barrel stage (16/8/4/2/1)
module shift_stage
    import shift_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] i_value,
    input  logic [2:0]        i_index,
    input  logic              i_op,
    input  logic              i_enable,
    output logic [DATA_W-1:0] o_value
);

    logic w_msb;
    assign w_msb = i_value[DATA_W-1];

    // Stage distance is 16 >> index; every distance is hard-wired, no variable shifter
    always_comb begin
        o_value = i_value;
        if (i_enable) begin
            case (i_index)
                3'd0: o_value = (i_op == OP_SRA) ? {{16{w_msb}}, i_value[31:16]} : {i_value[15:0], 16'b0};
                3'd1: o_value = (i_op == OP_SRA) ? {{8{w_msb}},  i_value[31:8]}  : {i_value[23:0], 8'b0};
                3'd2: o_value = (i_op == OP_SRA) ? {{4{w_msb}},  i_value[31:4]}  : {i_value[27:0], 4'b0};
                3'd3: o_value = (i_op == OP_SRA) ? {{2{w_msb}},  i_value[31:2]}  : {i_value[29:0], 2'b0};
                3'd4: o_value = (i_op == OP_SRA) ? {w_msb,       i_value[31:1]}  : {i_value[30:0], 1'b0};
                default: o_value = i_value;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - five-cycle SLL/SRA sequencer, one binary stage per cycle
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    shift_sequencer_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_amt;
    op_t               r_op;
    logic [2:0]        r_idx;
    logic              w_stage_en;
    logic [DATA_W-1:0] w_stage_out;
    logic              w_busy;
    logic              w_rdy;
    logic              w_accept;

    // Stage 0 handles distance 16, so it consumes the MSB of the shift amount
    always_comb begin
        w_stage_en = 1'b0;
        case (r_idx)
            3'd0:    w_stage_en = r_amt[4];
            3'd1:    w_stage_en = r_amt[3];
            3'd2:    w_stage_en = r_amt[2];
            3'd3:    w_stage_en = r_amt[1];
            3'd4:    w_stage_en = r_amt[0];
            default: w_stage_en = 1'b0;
        endcase
    end

    shift_stage u_stage (
        .i_value  (r_acc),
        .i_index  (r_idx),
        .i_op     (r_op),
        .i_enable (w_stage_en),
        .o_value  (w_stage_out)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and status outputs; a start is only honoured while not shifting
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_rdy        = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept     = bus.ctrl_shift;
                w_next_state = bus.ctrl_shift ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                w_busy       = 1'b1;
                w_next_state = (r_idx == 3'(NUM_STAGES - 1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                w_rdy        = 1'b1;
                w_accept     = bus.ctrl_shift;
                w_next_state = bus.ctrl_shift ? ST_SHIFT : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: the visible result only moves on SHIFT updates, so it holds through a new start
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_result <= '0;
            r_amt    <= '0;
            r_op     <= OP_SLL;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_acc <= bus.data_operandA;
            r_amt <= bus.ctrl_shiftamt;
            r_op  <= op_t'(bus.ctrl_op);
            r_idx <= '0;
        end else if (w_busy) begin
            r_acc    <= w_stage_out;
            r_result <= w_stage_out;
            r_idx    <= (r_idx == 3'(NUM_STAGES - 1)) ? 3'd0 : r_idx + 3'd1;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_resultRDY = w_rdy;
    assign bus.busy           = w_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic clock;
    logic reset;
    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference: a start while idle schedules the finished value 5 edges later
    logic        m_valid = 1'b0;
    logic        m_busy, m_rdy;
    logic [31:0] m_result, m_pending;
    int          m_cnt = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 1'b0; m_rdy = 1'b0; m_result = 32'h0; m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_busy = (m_cnt != 0);
            m_rdy  = (m_cnt == 0);
            if (m_cnt == 0) m_result = m_pending;
        end else begin
            m_rdy = 1'b0;
            if (bus.ctrl_shift) begin
                if (bus.ctrl_op)
                    m_pending = $unsigned($signed(bus.data_operandA) >>> bus.ctrl_shiftamt);
                else
                    m_pending = bus.data_operandA << bus.ctrl_shiftamt;
                m_cnt  = 5;
                m_busy = 1'b1;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_busy", 32'(bus.busy), 32'(m_busy));
            check("model_rdy", 32'(bus.data_resultRDY), 32'(m_rdy));
            if (!m_busy) check("model_result", bus.data_result, m_result);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic op, input logic [31:0] a, input logic [4:0] amt,
                         input logic [31:0] exp, input string name, input bit hold);
        int n;
        int nbusy;
        bus.ctrl_shift    = 1'b1;
        bus.ctrl_op       = op;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = amt;
        tick();
        n = 1;
        nbusy = 0;
        bus.ctrl_shift    = hold;
        bus.data_operandA = $urandom;
        bus.ctrl_shiftamt = 5'($urandom);
        bus.ctrl_op       = 1'($urandom);
        while (!bus.data_resultRDY && n < 12) begin
            nbusy += int'(bus.busy);
            tick();
            n++;
            if (n >= 5) bus.ctrl_shift = 1'b0;
        end
        bus.ctrl_shift = 1'b0;
        check({name, "_latency"}, 32'(n), 32'd6);
        check({name, "_result"}, bus.data_result, exp);
        check({name, "_busy_cycles"}, 32'(nbusy), 32'd5);
    endtask

    initial begin
        reset             = 1'b1;
        bus.ctrl_shift    = 1'b0;
        bus.ctrl_op       = 1'b0;
        bus.data_operandA = 32'h0;
        bus.ctrl_shiftamt = 5'd0;
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset_result", bus.data_result, 32'h0);
        reset = 1'b0;
        tick();

        do_op(1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra_msb_4", 1'b0);   tick();
        do_op(1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_1_31", 1'b0);    tick();
        do_op(1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, "sra_7f_31", 1'b0);   tick();
        do_op(1'b1, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, "sra_ff_31", 1'b0);   tick();
        do_op(1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, "sll_amt0", 1'b0);    tick();
        do_op(1'b1, 32'h1234_5678, 5'd0,  32'h1234_5678, "sra_amt0", 1'b0);    tick();
        do_op(1'b0, 32'h0000_00F3, 5'd21, 32'h1E60_0000, "hold_start", 1'b1);  tick();

        do_op(1'b0, 32'h0000_000F, 5'd4,  32'h0000_00F0, "b2b_first", 1'b0);
        do_op(1'b1, 32'hF000_0000, 5'd8,  32'hFFF0_0000, "b2b_second", 1'b0);
        tick();

        bus.ctrl_shift    = 1'b1;
        bus.ctrl_op       = 1'b0;
        bus.data_operandA = 32'h0000_AAAA;
        bus.ctrl_shiftamt = 5'd3;
        tick();
        bus.ctrl_shift = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midrst_result", bus.data_result, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_rdy", 32'(bus.data_resultRDY), 32'd0);
        end
        do_op(1'b1, 32'hC000_0003, 5'd1, 32'hE000_0001, "after_reset", 1'b0);
        tick();

        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 99) == 0);
            bus.ctrl_shift    = ($urandom_range(0, 2) == 0);
            bus.ctrl_op       = 1'($urandom);
            bus.data_operandA = $urandom;
            bus.ctrl_shiftamt = 5'($urandom);
            tick();
        end
        reset          = 1'b0;
        bus.ctrl_shift = 1'b0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
